// File: rtl/pmem_arbiter.sv
// Two-way arbiter sharing one physical-memory port between the I-cache and D-cache controllers.
// One line transaction at a time: IDLE grants, BUSY drives pmem, DONE pulses the owner's resp.
module pmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int LINE_W   = 128,
   parameter int ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_pmem_read,
   input  logic              i_pmem_write,
   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic [LINE_W-1:0] i_pmem_wdata,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;   // 1 = D-cache
   logic              op_q, op_d;         // 1 = write
   logic              last_q, last_d;     // 1 = D-cache granted last
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] rdata_q, rdata_d;

   logic i_req, d_req, grant_d, sel_wr;

   assign i_req = i_pmem_read | i_pmem_write;
   assign d_req = d_pmem_read | d_pmem_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         op_q    <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Tie-break: fixed D priority, or alternate away from the previous winner.
   always_comb begin
      grant_d = d_req;
      if (i_req && d_req)
         grant_d = (ARB_MODE == 0) ? 1'b1 : ~last_q;
      sel_wr = grant_d ? d_pmem_write : i_pmem_write;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      op_d    = op_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d = BUSY;
               owner_d = grant_d;
               last_d  = grant_d;
               op_d    = sel_wr;
               addr_d  = grant_d ? d_pmem_address : i_pmem_address;
               wdata_d = sel_wr ? (grant_d ? d_pmem_wdata : i_pmem_wdata) : '0;
            end
         end
         BUSY: begin
            if (pmem_resp) begin
               state_d = DONE;
               rdata_d = pmem_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pmem_read    = (state_q == BUSY) & ~op_q;
      pmem_write   = (state_q == BUSY) &  op_q;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      i_pmem_resp  = (state_q == DONE) & ~owner_q;
      d_pmem_resp  = (state_q == DONE) &  owner_q;
      i_pmem_rdata = rdata_q;
      d_pmem_rdata = rdata_q;
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: u0 runs fixed priority, u1 runs round-robin.
module tb_pmem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         ird[2], iwr[2], drd[2], dwr[2], presp[2];
   logic [15:0]  iaddr[2], daddr[2], paddr[2];
   logic [127:0] iwd[2], dwd[2], prdata[2], irdata[2], drdata[2], pwdata[2];
   logic         iresp[2], dresp[2], prd[2], pwr[2];

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] LA = {8{16'hAAAA}};
   localparam logic [127:0] L5 = {16{8'h55}};
   localparam logic [127:0] L3 = {16{8'h33}};

   pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .ARB_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .i_pmem_read(ird[0]), .i_pmem_write(iwr[0]), .i_pmem_address(iaddr[0]), .i_pmem_wdata(iwd[0]),
      .i_pmem_rdata(irdata[0]), .i_pmem_resp(iresp[0]),
      .d_pmem_read(drd[0]), .d_pmem_write(dwr[0]), .d_pmem_address(daddr[0]), .d_pmem_wdata(dwd[0]),
      .d_pmem_rdata(drdata[0]), .d_pmem_resp(dresp[0]),
      .pmem_read(prd[0]), .pmem_write(pwr[0]), .pmem_address(paddr[0]), .pmem_wdata(pwdata[0]),
      .pmem_rdata(prdata[0]), .pmem_resp(presp[0]));

   pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .ARB_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .i_pmem_read(ird[1]), .i_pmem_write(iwr[1]), .i_pmem_address(iaddr[1]), .i_pmem_wdata(iwd[1]),
      .i_pmem_rdata(irdata[1]), .i_pmem_resp(iresp[1]),
      .d_pmem_read(drd[1]), .d_pmem_write(dwr[1]), .d_pmem_address(daddr[1]), .d_pmem_wdata(dwd[1]),
      .d_pmem_rdata(drdata[1]), .d_pmem_resp(dresp[1]),
      .pmem_read(prd[1]), .pmem_write(pwr[1]), .pmem_address(paddr[1]), .pmem_wdata(pwdata[1]),
      .pmem_rdata(prdata[1]), .pmem_resp(presp[1]));

   // {i_resp, d_resp, pmem_read, pmem_write}
   function automatic logic [3:0] st(input int m);
      return {iresp[m], dresp[m], prd[m], pwr[m]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [15:0] rr_addr[4];

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ird[k] = 0; iwr[k] = 0; drd[k] = 0; dwr[k] = 0; presp[k] = 0;
         iaddr[k] = '0; daddr[k] = '0; iwd[k] = '0; dwd[k] = '0; prdata[k] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_ctl",   128'(st(0)), 128'h0);
      chk("rst_addr",  128'(paddr[0]), 128'h0);
      chk("rst_rdata", irdata[0], 128'h0);
      chk("rst_ctl1",  128'(st(1)), 128'h0);
      rst_n = 1'b1;

      // I read alone; memory answers in the 4th strobe cycle
      ird[0] = 1; iaddr[0] = 16'h1230; iwd[0] = 128'hDEAD;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t1_strobe", 128'(st(0)), 128'b0010);
         chk("t1_addr", 128'(paddr[0]), 128'h1230);
         if (c == 3) begin presp[0] = 1; prdata[0] = LA; end
      end
      chk("t1_wdata", pwdata[0], 128'h0);
      @(negedge clk);
      presp[0] = 0; ird[0] = 0;
      chk("t1_resp", 128'(st(0)), 128'b1000);
      chk("t1_irdata", irdata[0], LA);
      chk("t1_drdata", drdata[0], LA);
      @(negedge clk);
      chk("t1_idle", 128'(st(0)), 128'h0);

      // Simultaneous I read / D write, fixed priority: D first
      ird[0] = 1; iaddr[0] = 16'h0100;
      dwr[0] = 1; daddr[0] = 16'h2000; dwd[0] = L5;
      @(negedge clk);
      chk("t2_d_strobe", 128'(st(0)), 128'b0001);
      chk("t2_d_addr", 128'(paddr[0]), 128'h2000);
      chk("t2_d_wdata", pwdata[0], L5);
      chk("t2_hold", irdata[0], LA);
      presp[0] = 1; prdata[0] = 128'hFEED;
      @(negedge clk);
      presp[0] = 0; dwr[0] = 0;
      chk("t2_d_resp", 128'(st(0)), 128'b0100);
      chk("t2_wcap", drdata[0], 128'hFEED);
      @(negedge clk);
      chk("t2_gap", 128'(st(0)), 128'h0);
      @(negedge clk);
      chk("t2_i_strobe", 128'(st(0)), 128'b0010);
      chk("t2_i_addr", 128'(paddr[0]), 128'h0100);
      chk("t2_i_wdata", pwdata[0], 128'h0);
      presp[0] = 1; prdata[0] = 128'h1111;
      @(negedge clk);
      presp[0] = 0; ird[0] = 0;
      chk("t2_i_resp", 128'(st(0)), 128'b1000);
      @(negedge clk);
      chk("t2_idle", 128'(st(0)), 128'h0);

      // Round-robin with both sides requesting continuously: D,I,D,I
      rr_addr[0] = 16'h0D00; rr_addr[1] = 16'h0A00; rr_addr[2] = 16'h0D00; rr_addr[3] = 16'h0A00;
      ird[1] = 1; iaddr[1] = 16'h0A00;
      drd[1] = 1; daddr[1] = 16'h0D00;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk("t3_strobe", 128'(st(1)), 128'b0010);
         chk("t3_order", 128'(paddr[1]), 128'(rr_addr[t]));
         presp[1] = 1; prdata[1] = 128'(t + 1);
         @(negedge clk);
         presp[1] = 0;
         if (t == 3) begin ird[1] = 0; drd[1] = 0; end
         chk("t3_resp", 128'(st(1)), (t % 2 == 0) ? 128'b0100 : 128'b1000);
         @(negedge clk);
         chk("t3_gap", 128'(st(1)), 128'h0);
      end

      // Reset mid-BUSY of a D read, then a late pmem_resp
      drd[0] = 1; daddr[0] = 16'h4000;
      @(negedge clk);
      chk("t4_strobe", 128'(st(0)), 128'b0010);
      #2 rst_n = 1'b0; drd[0] = 0;
      #1;
      chk("t4_async", 128'(st(0)), 128'h0);
      chk("t4_addr0", 128'(paddr[0]), 128'h0);
      chk("t4_rdata0", irdata[0], 128'h0);
      @(negedge clk);
      rst_n = 1'b1; presp[0] = 1; prdata[0] = {8{16'hEEEE}};
      @(negedge clk);
      presp[0] = 0;
      chk("t4_late", 128'(st(0)), 128'h0);
      chk("t4_nocap", drdata[0], 128'h0);
      @(negedge clk);
      chk("t4_quiet", 128'(st(0)), 128'h0);
      drd[0] = 1; daddr[0] = 16'h4010;
      @(negedge clk);
      chk("t4_re_strobe", 128'(st(0)), 128'b0010);
      chk("t4_re_addr", 128'(paddr[0]), 128'h4010);
      presp[0] = 1; prdata[0] = 128'hBEEF;
      @(negedge clk);
      presp[0] = 0; drd[0] = 0;
      chk("t4_re_resp", 128'(st(0)), 128'b0100);
      chk("t4_re_data", drdata[0], 128'hBEEF);
      @(negedge clk);
      chk("t4_idle", 128'(st(0)), 128'h0);

      // Spurious pmem_resp while idle
      presp[0] = 1; prdata[0] = {8{16'hCCCC}};
      @(negedge clk);
      presp[0] = 0;
      chk("t5_ignore", 128'(st(0)), 128'h0);
      chk("t5_hold", drdata[0], 128'hBEEF);
      @(negedge clk);
      chk("t5_still", 128'(st(0)), 128'h0);

      // D read+write together is a write
      drd[0] = 1; dwr[0] = 1; daddr[0] = 16'h3000; dwd[0] = L3;
      @(negedge clk);
      chk("t6_strobe", 128'(st(0)), 128'b0001);
      chk("t6_addr", 128'(paddr[0]), 128'h3000);
      chk("t6_wdata", pwdata[0], L3);
      presp[0] = 1;
      @(negedge clk);
      presp[0] = 0; drd[0] = 0; dwr[0] = 0;
      chk("t6_resp", 128'(st(0)), 128'b0100);
      @(negedge clk);
      chk("t6_once", 128'(st(0)), 128'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
